// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: default IF/ID widths and entry layout {pc, instr, pred}, with pred in bit 0.
package if_id_queue_pkg;
   localparam int Instruction_Address_size = 32;
   localparam int Instruction_size = 32;
   localparam int ENTRY_W = Instruction_Address_size + Instruction_size + 1;
   localparam int PRED_OFF = 0;
   localparam int INSTR_OFF = 1;
   localparam int PC_OFF = INSTR_OFF + Instruction_size;
   function automatic int entry_w(int aw, int iw);
      return aw + iw + 1;
   endfunction
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x EW register array, one write port and one async read port, no reset.
module if_id_queue_mem import if_id_queue_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int EW = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [EW-1:0]            wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [EW-1:0]            rdata_o
);
   logic [EW-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF->ID decoupling FIFO with valid/ready on both sides and single-cycle discard.
// Define IF_ID_BYPASS_EN for a combinational in->out path when the queue is empty.
module if_id_queue import if_id_queue_pkg::*; #(
   parameter int ADDR_W = Instruction_Address_size,
   parameter int INSTR_W = Instruction_size,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_pc,
   input  logic [INSTR_W-1:0]         in_instr,
   input  logic                       in_pred,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [INSTR_W-1:0]         out_instr,
   output logic                       out_pred,
   input  logic                       discard,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = entry_w(ADDR_W, INSTR_W);
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] rd_data, head;
   logic byp, push, pop;
`ifdef IF_ID_BYPASS_EN
   // Bypass is held off while reset is asserted so reset always presents a bubble.
   assign byp = rst && count_q == '0 && in_valid && !discard;
`else
   assign byp = 1'b0;
`endif
   assign in_ready = count_q != CW'(DEPTH);
   assign out_valid = count_q != '0 || byp;
   assign pop = count_q != '0 && out_ready;
   assign push = in_valid && in_ready && !(byp && out_ready);
   assign count = count_q;
   always_comb begin
      wr_d = discard ? '0 : wr_q + PW'(push);
      rd_d = discard ? '0 : rd_q + PW'(pop);
      count_d = discard ? '0 : count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         count_q <= count_d;
      end
   if_id_queue_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
      .clk(clk),
      .we_i(push && !discard),
      .waddr_i(wr_q),
      .wdata_i({in_pc, in_instr, in_pred}),
      .raddr_i(rd_q),
      .rdata_o(rd_data)
   );
   assign head = byp ? {in_pc, in_instr, in_pred} : rd_data;
   assign out_pc = out_valid ? head[INSTR_OFF+INSTR_W +: ADDR_W] : '0;
   assign out_instr = out_valid ? head[INSTR_OFF +: INSTR_W] : '0;
   assign out_pred = out_valid ? head[PRED_OFF] : 1'b0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_id_queue;
   localparam int DEPTH = 4;
   logic clk = 0, rst = 0, in_valid = 0, in_pred = 0, out_ready = 0, discard = 0;
   logic [31:0] in_pc = 0, in_instr = 0;
   logic in_ready, out_valid, out_pred;
   logic [31:0] out_pc, out_instr;
   logic [2:0] count;
   int total = 0, bad = 0;
   logic [64:0] mq[$];

   if_id_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instr(in_instr), .in_pred(in_pred), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_pred(out_pred), .discard(discard), .count(count)
   );

   always #5 clk = ~clk;

   function automatic bit model_byp();
`ifdef IF_ID_BYPASS_EN
      return rst && mq.size() == 0 && in_valid && !discard;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      bit b, pop, push, d;
      logic [64:0] e;
      b = model_byp();
      pop = out_ready && mq.size() > 0;
      push = in_valid && mq.size() < DEPTH && !(b && out_ready);
      d = discard || !rst;
      e = {in_pc, in_instr, in_pred};
      @(posedge clk);
      if (d) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic flush();
      in_valid = 0; out_ready = 0; discard = 1;
      tick();
      discard = 0;
   endtask

   task automatic test_reset();
      rst = 0; in_valid = 1; in_pc = 32'h123; in_instr = 32'h1; out_ready = 0;
      @(negedge clk); #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      in_valid = 0; rst = 1;
      @(negedge clk);
      in_valid = 1; in_pc = 32'h100; in_instr = 32'h00500093; in_pred = 1;
      tick();
      in_valid = 0; in_pred = 0; #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL first_pc got=%h exp=100", out_pc); end
      total++; if (out_instr !== 32'h00500093) begin bad++; $display("FAIL first_instr got=%h exp=00500093", out_instr); end
      total++; if (out_pred !== 1'b1) begin bad++; $display("FAIL first_pred got=%b exp=1", out_pred); end
      flush();
   endtask

   task automatic test_fill();
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_pc = 32'(4 * i); in_instr = $urandom; in_pred = 1'($urandom);
         tick();
      end
      in_valid = 0; #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      in_valid = 1; in_pc = 32'h10;
      tick();
      in_valid = 0; #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_overflow_count got=%0d exp=4", count); end
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (out_pc !== 32'(4 * i)) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, out_pc, 4 * i); end
         tick();
      end
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
      out_ready = 0;
      flush();
   endtask

   task automatic test_wrap();
      out_ready = 0; in_valid = 1;
      in_pc = 32'h20; tick();
      in_pc = 32'h24; tick();
      out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         in_pc = 32'(32'h28 + 4 * k); #1;
         total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=2", k, count); end
         total++; if (out_pc !== 32'(32'h20 + 4 * k)) begin bad++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", k, out_pc, 32'h20 + 4 * k); end
         tick();
      end
      flush();
   endtask

   task automatic test_discard();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_pc = 32'(32'h300 + 4 * i); tick();
      end
      in_valid = 0; #1;
      total++; if (count !== 3'd3) begin bad++; $display("FAIL disc_pre_count got=%0d exp=3", count); end
      discard = 1; in_valid = 1; in_pc = 32'hDEAD0; out_ready = 1;
      tick();
      discard = 0; in_valid = 0; #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL disc_count got=%0d exp=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL disc_valid got=%b exp=0", out_valid); end
      out_ready = 0;
      tick(); tick(); #1;
      total++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin bad++; $display("FAIL disc_ghost valid=%b pc=%h exp valid=0 pc=0", out_valid, out_pc); end
   endtask

   task automatic test_async_reset();
      out_ready = 0; in_valid = 1;
      in_pc = 32'h400; tick();
      in_pc = 32'h404; tick();
      in_valid = 0; #1;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL arst_pre_count got=%0d exp=2", count); end
      #1 rst = 0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
      mq.delete();
      #1 rst = 1;
      @(negedge clk);
   endtask

   task automatic test_bypass();
      in_valid = 1; in_pc = 32'h200; in_instr = 32'h13; out_ready = 1; #1;
`ifdef IF_ID_BYPASS_EN
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin bad++; $display("FAIL byp_same_cycle valid=%b pc=%h exp valid=1 pc=200", out_valid, out_pc); end
`else
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL byp_off_valid got=%b exp=0", out_valid); end
`endif
      tick();
      in_valid = 0; out_ready = 0; #1;
`ifdef IF_ID_BYPASS_EN
      total++; if (count !== 3'd0) begin bad++; $display("FAIL byp_count got=%0d exp=0", count); end
`else
      total++; if (count !== 3'd1 || out_pc !== 32'h200) begin bad++; $display("FAIL byp_off_count count=%0d pc=%h exp count=1 pc=200", count, out_pc); end
`endif
      flush();
   endtask

   task automatic test_random();
      logic [64:0] exp_e;
      bit exp_v;
      for (int n = 0; n < 400; n++) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         discard = $urandom_range(0, 19) == 0;
         in_pc = $urandom; in_instr = $urandom; in_pred = 1'($urandom);
         #1;
         exp_v = mq.size() > 0 || model_byp();
         exp_e = mq.size() > 0 ? mq[0] : (model_byp() ? {in_pc, in_instr, in_pred} : 65'd0);
         total++; if (out_valid !== exp_v) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, out_valid, exp_v); end
         total++; if ({out_pc, out_instr, out_pred} !== exp_e) begin bad++; $display("FAIL rnd_head[%0d] got=%h exp=%h", n, {out_pc, out_instr, out_pred}, exp_e); end
         total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, count, mq.size()); end
         total++; if (in_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", n, in_ready, mq.size() < DEPTH); end
         tick();
      end
      flush();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_discard();
      test_async_reset();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
